// File: rtl/uart_frame_sequencer.sv
// Frames INPUT_SIZE-bit symbols after a sync symbol into OUTPUT_SIZE-bit words with a one-word skid.
// Optional macro UART_SEQ_WORD_COUNT_EN enables the saturating delivered-word counter on word_count.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_IDLE    | hunting for SYNC_SYMBOL, other symbols dropped
// S_COLLECT | shifting symbols into the word, idle timer running
// S_STALL   | completed word held, waiting for word_out to drain
module uart_frame_sequencer #(
  parameter int                    OUTPUT_SIZE    = 16,
  parameter int                    INPUT_SIZE     = 4,
  parameter logic [INPUT_SIZE-1:0] SYNC_SYMBOL    = INPUT_SIZE'(4'hA),
  parameter int                    TIMEOUT_CYCLES = 255
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [INPUT_SIZE-1:0]  sym_in,
  input  logic                   sym_valid,
  output logic                   sym_ready,
  output logic [OUTPUT_SIZE-1:0] word_out,
  output logic                   word_valid,
  input  logic                   word_ready,
  input  logic                   err_clear,
  output logic                   frame_active,
  output logic                   timeout_err,
  output logic [15:0]            word_count
);

  localparam int N  = OUTPUT_SIZE / INPUT_SIZE;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam int IW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(N - 1);
  localparam logic [IW-1:0] IDLE_LAST = IW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_STALL} state_t;

  state_t                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [IW-1:0]          idle_q, idle_d;
  logic [OUTPUT_SIZE-1:0] shreg_q, shreg_d;
  logic [OUTPUT_SIZE-1:0] held_q, held_d;
  logic [OUTPUT_SIZE-1:0] word_q, word_d;
  logic                   valid_q, valid_d;
  logic                   err_q, err_d;
  logic                   word_load;
  logic [OUTPUT_SIZE-1:0] assembled;

  assign assembled = {shreg_q[OUTPUT_SIZE-INPUT_SIZE-1:0], sym_in};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idle_q  <= '0;
      shreg_q <= '0;
      held_q  <= '0;
      word_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idle_q  <= idle_d;
      shreg_q <= shreg_d;
      held_q  <= held_d;
      word_q  <= word_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idle_d    = idle_q;
    shreg_d   = shreg_q;
    held_d    = held_q;
    word_d    = word_q;
    valid_d   = valid_q & ~word_ready;
    err_d     = err_q & ~err_clear;
    word_load = 1'b0;
    sym_ready = 1'b1;
    case (state_q)
      S_IDLE: begin
        cnt_d  = '0;
        idle_d = '0;
        if (sym_valid && sym_in == SYNC_SYMBOL) state_d = S_COLLECT;
      end
      S_COLLECT: begin
        if (sym_valid) begin
          idle_d  = '0;
          shreg_d = assembled;
          if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            if (!valid_q || word_ready) begin
              word_d    = assembled;
              word_load = 1'b1;
            end else begin
              held_d  = assembled;
              state_d = S_STALL;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end else if (idle_q == IDLE_LAST) begin
          // partial word is dropped; any word already on word_out stays pending
          idle_d  = '0;
          cnt_d   = '0;
          state_d = S_IDLE;
          if (cnt_q != '0) err_d = 1'b1;
        end else begin
          idle_d = idle_q + 1'b1;
        end
      end
      S_STALL: begin
        sym_ready = 1'b0;
        idle_d    = '0;
        if (word_ready) begin
          word_d    = held_q;
          word_load = 1'b1;
          state_d   = S_COLLECT;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (word_load) valid_d = 1'b1;
  end

  assign word_out     = word_q;
  assign word_valid   = valid_q;
  assign timeout_err  = err_q;
  assign frame_active = (state_q != S_IDLE);

`ifdef UART_SEQ_WORD_COUNT_EN
  logic [15:0] word_count_q;

  always_ff @(posedge clk) begin
    if (!rst_n) word_count_q <= '0;
    else if (word_load && word_count_q != 16'hFFFF) word_count_q <= word_count_q + 16'd1;
  end

  assign word_count = word_count_q;
`else
  assign word_count = 16'h0000;
`endif

endmodule

// File: tb/tb_uart_frame_sequencer.sv
// Scoreboarded bench for uart_frame_sequencer: directed frames plus randomized frames/backpressure.
// Expected word_count follows UART_SEQ_WORD_COUNT_EN the same way the design build does.
module tb_uart_frame_sequencer;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  sym_in = '0;
  logic        sym_valid = 1'b0;
  logic        sym_ready;
  logic [15:0] word_out;
  logic        word_valid;
  logic        word_ready = 1'b0;
  logic        err_clear = 1'b0;
  logic        frame_active;
  logic        timeout_err;
  logic [15:0] word_count;

  int          checks = 0;
  int          errors = 0;
  logic [15:0] exp_q[$];
  int          exp_loaded = 0;
  bit          rand_ready = 1'b0;
  bit          prev_hold = 1'b0;
  logic [15:0] prev_word = '0;

  uart_frame_sequencer dut (
    .clk(clk), .rst_n(rst_n), .sym_in(sym_in), .sym_valid(sym_valid), .sym_ready(sym_ready),
    .word_out(word_out), .word_valid(word_valid), .word_ready(word_ready), .err_clear(err_clear),
    .frame_active(frame_active), .timeout_err(timeout_err), .word_count(word_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] exp_wc();
`ifdef UART_SEQ_WORD_COUNT_EN
    return (exp_loaded > 65535) ? 32'hFFFF : 32'(exp_loaded);
`else
    return 32'h0;
`endif
  endfunction

  // Inputs change 1 time unit after a rising edge; everything is sampled on falling edges.
  task automatic realign();
    @(posedge clk); #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    sym_valid = 1'b0;
    repeat (n) realign();
  endtask

  task automatic send_sym(input logic [3:0] v);
    int t;
    sym_in = v;
    sym_valid = 1'b1;
    t = 0;
    @(negedge clk);
    while (!sym_ready && t < 1000) begin
      @(negedge clk);
      t++;
    end
    if (!sym_ready) check("sym_accept_bound", 32'(sym_ready), 32'h1);
    realign();
    sym_valid = 1'b0;
  endtask

  task automatic send_word(input logic [15:0] w, input int max_gap);
    exp_q.push_back(w);
    exp_loaded++;
    for (int i = 3; i >= 0; i--) begin
      if (max_gap > 0) idle($urandom_range(0, max_gap));
      send_sym(w[i*4 +: 4]);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    realign();
    rst_n = 1'b1;
    exp_q.delete();
    exp_loaded = 0;
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 2000) begin
      idle(1);
      t++;
    end
    check("drain", 32'(exp_q.size()), 32'h0);
  endtask

  task automatic check_frame_end(input string tag);
    at_neg();
    check({tag, "_frame_active"}, 32'(frame_active), 32'h0);
    check({tag, "_timeout_err"}, 32'(timeout_err), 32'h0);
    realign();
  endtask

  always @(posedge clk) begin
    #2;
    if (rand_ready) word_ready = 1'($urandom_range(0, 1));
  end

  always @(negedge clk) begin
    if (prev_hold) begin
      check("hold_valid", 32'(word_valid), 32'h1);
      check("hold_stable", 32'(word_out), 32'(prev_word));
    end
    if (rst_n && word_valid && word_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_word: got %0h expected none", word_out);
      end else begin
        check("word", 32'(word_out), 32'(exp_q.pop_front()));
      end
    end
    prev_hold = rst_n && word_valid && !word_ready;
    prev_word = word_out;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] w;
    logic [3:0]  g;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    at_neg();
    check("rst_sym_ready", 32'(sym_ready), 32'h1);
    check("rst_word_out", 32'(word_out), 32'h0);
    check("rst_word_valid", 32'(word_valid), 32'h0);
    check("rst_frame_active", 32'(frame_active), 32'h0);
    check("rst_timeout_err", 32'(timeout_err), 32'h0);
    check("rst_word_count", 32'(word_count), 32'h0);
    realign();

    // basic frame, one cycle latency after the last symbol
    word_ready = 1'b1;
    send_sym(4'hA);
    send_word(16'h1234, 0);
    at_neg();
    check("t1_valid", 32'(word_valid), 32'h1);
    check("t1_word", 32'(word_out), 32'h1234);
    check("t1_count", 32'(word_count), exp_wc());
    realign();
    idle(255);
    check_frame_end("t1");

    // non-sync symbol in IDLE is dropped
    send_sym(4'h5);
    at_neg();
    check("t2_no_frame", 32'(frame_active), 32'h0);
    realign();
    send_sym(4'hA);
    send_word(16'h1234, 0);
    idle(255);
    check_frame_end("t2");

    // backpressure into STALL; second word carries the sync value as data
    word_ready = 1'b0;
    send_sym(4'hA);
    send_word(16'h9C3E, 0);
    send_word(16'hA5AA, 0);
    at_neg();
    check("t3_stall_ready", 32'(sym_ready), 32'h0);
    check("t3_word1", 32'(word_out), 32'h9C3E);
    realign();
    word_ready = 1'b1;
    at_neg();
    realign();
    at_neg();
    check("t3_word2", 32'(word_out), 32'hA5AA);
    check("t3_collect_ready", 32'(sym_ready), 32'h1);
    check("t3_frame_active", 32'(frame_active), 32'h1);
    realign();
    idle(255);
    check_frame_end("t3");
    at_neg();
    check("t3_count", 32'(word_count), exp_wc());
    realign();

    // timeout with a partial word, exact boundary
    send_sym(4'hA);
    send_sym(4'h1);
    send_sym(4'h2);
    idle(254);
    at_neg();
    check("t4_before_active", 32'(frame_active), 32'h1);
    check("t4_before_err", 32'(timeout_err), 32'h0);
    realign();
    at_neg();
    check("t4_after_active", 32'(frame_active), 32'h0);
    check("t4_after_err", 32'(timeout_err), 32'h1);
    realign();
    err_clear = 1'b1;
    realign();
    err_clear = 1'b0;
    at_neg();
    check("t4_cleared", 32'(timeout_err), 32'h0);
    realign();

    // set beats a simultaneous clear; pending word survives the timeout
    word_ready = 1'b0;
    send_sym(4'hA);
    send_word(16'h3C5F, 0);
    send_sym(4'h7);
    err_clear = 1'b1;
    idle(255);
    err_clear = 1'b0;
    at_neg();
    check("t5_err_set_wins", 32'(timeout_err), 32'h1);
    check("t5_pending_valid", 32'(word_valid), 32'h1);
    check("t5_pending_word", 32'(word_out), 32'h3C5F);
    realign();
    word_ready = 1'b1;
    realign();
    realign();
    err_clear = 1'b1;
    realign();
    err_clear = 1'b0;
    at_neg();
    check("t5_cleared", 32'(timeout_err), 32'h0);
    check("t5_drained", 32'(word_valid), 32'h0);
    realign();

    // reset mid-frame, then a clean frame
    send_sym(4'hA);
    send_sym(4'h1);
    send_sym(4'h2);
    send_sym(4'h3);
    do_reset();
    at_neg();
    check("t6_valid", 32'(word_valid), 32'h0);
    check("t6_count", 32'(word_count), 32'h0);
    check("t6_active", 32'(frame_active), 32'h0);
    realign();
    send_sym(4'hA);
    send_word(16'h4567, 0);
    at_neg();
    check("t6_word", 32'(word_out), 32'h4567);
    realign();
    idle(255);
    check_frame_end("t6");

    // reset while stalled drops both words
    word_ready = 1'b0;
    send_sym(4'hA);
    send_word(16'($urandom), 0);
    send_word(16'($urandom), 0);
    do_reset();
    at_neg();
    check("t7_valid", 32'(word_valid), 32'h0);
    check("t7_sym_ready", 32'(sym_ready), 32'h1);
    check("t7_count", 32'(word_count), 32'h0);
    realign();

    // randomized frames with random gaps and backpressure
    for (int f = 0; f < 5; f++) begin
      rand_ready = 1'b1;
      for (int n = $urandom_range(0, 3); n > 0; n--) begin
        do g = 4'($urandom_range(0, 15)); while (g == 4'hA);
        send_sym(g);
      end
      send_sym(4'hA);
      for (int k = $urandom_range(1, 4); k > 0; k--) begin
        w = 16'($urandom);
        send_word(w, 3);
      end
      rand_ready = 1'b0;
      word_ready = 1'b1;
      wait_drain();
      idle(256);
      check_frame_end("rnd");
      at_neg();
      check("rnd_count", 32'(word_count), exp_wc());
      realign();
    end

    check("final_queue_empty", 32'(exp_q.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/uart_frame_sequencer.md
UART_FRAME_SEQUENCER -- requirements
Module: uart_frame_sequencer

Interface
REQ-001 The block SHALL have parameter OUTPUT_SIZE, default 16: assembled word width in bits.
REQ-002 The block SHALL have parameter INPUT_SIZE, default 4: symbol width in bits; OUTPUT_SIZE/INPUT_SIZE (N) SHALL be an integer >= 2.
REQ-003 The block SHALL have parameter SYNC_SYMBOL, default 4'hA: frame-start symbol, INPUT_SIZE bits wide.
REQ-004 The block SHALL have parameter TIMEOUT_CYCLES, default 255: idle-cycle limit, >= 1.
REQ-005 Port clk SHALL be an input, 1 bit: single clock; all logic SHALL be on its rising edge.
REQ-006 Port rst_n SHALL be an input, 1 bit: synchronous, active-low reset.
REQ-007 Port sym_in SHALL be an input, INPUT_SIZE bits: incoming symbol.
REQ-008 Port sym_valid SHALL be an input, 1 bit: sym_in valid.
REQ-009 Port sym_ready SHALL be an output, 1 bit: symbol accepted when sym_valid and sym_ready are both 1.
REQ-010 Port word_out SHALL be an output, OUTPUT_SIZE bits: assembled word.
REQ-011 Port word_valid SHALL be an output, 1 bit: word_out holds an undelivered word.
REQ-012 Port word_ready SHALL be an input, 1 bit: downstream accept; transfer occurs when word_valid and word_ready are both 1.
REQ-013 Port err_clear SHALL be an input, 1 bit: clears timeout_err.
REQ-014 Port frame_active SHALL be an output, 1 bit: 1 whenever state is not IDLE.
REQ-015 Port timeout_err SHALL be an output, 1 bit: sticky flag indicating a partial word was discarded.
REQ-016 Port word_count SHALL be an output, 16 bits: count of words delivered to word_out.

Function
REQ-017 The block SHALL implement states IDLE, COLLECT and STALL.
REQ-018 In IDLE: sym_ready=1; an accepted symbol equal to SYNC_SYMBOL SHALL move the block to COLLECT with symbol count=0; any other accepted symbol SHALL be discarded.
REQ-019 In COLLECT: sym_ready=1; each accepted symbol SHALL shift in MSB-first (shreg <= {shreg[OUTPUT_SIZE-INPUT_SIZE-1:0], sym_in}) and increment the symbol count; SYNC_SYMBOL SHALL be treated as ordinary data.
REQ-020 On the Nth accepted symbol, if word_valid=0 or word_ready=1 that cycle, the block SHALL load the completed word into word_out, set word_valid=1 on the next edge, reset the count to 0 and remain in COLLECT (zero-bubble; latency = 1 cycle after the last symbol).
REQ-021 On the Nth accepted symbol, if word_valid=1 and word_ready=0, the block SHALL hold the completed word internally and enter STALL.
REQ-022 In STALL: sym_ready=0; on word_ready=1, word_out SHALL load the held word, word_valid SHALL remain 1, and the block SHALL return to COLLECT with count 0.
REQ-023 word_valid SHALL clear after a transfer unless a new word loads in the same cycle; word_out SHALL be stable while word_valid=1 and word_ready=0.
REQ-024 An idle counter SHALL count consecutive COLLECT cycles with no accepted symbol, resetting on each accepted symbol; STALL SHALL hold it at 0.
REQ-025 When the idle counter reaches TIMEOUT_CYCLES with count=0, the block SHALL return to IDLE with no error (normal frame end).
REQ-026 When the idle counter reaches TIMEOUT_CYCLES with count>0, the block SHALL discard the partial word, set timeout_err and return to IDLE; a pending word_out SHALL be preserved.
REQ-027 err_clear SHALL clear timeout_err; when a set event and err_clear coincide, the set SHALL win.
REQ-028 word_count SHALL increment on each word load into word_out, saturate at 16'hFFFF, and clear only on reset.

Reset
REQ-029 When rst_n=0 at a clock edge, the block SHALL enter IDLE and clear the symbol count, idle counter, shreg and held word.
REQ-030 Reset values: sym_ready=1 on the first cycle after release; word_out=0; word_valid=0; frame_active=0; timeout_err=0; word_count=0.
REQ-031 Reset mid-frame or mid-STALL SHALL drop all partial and pending data without emitting a word.

Configuration
REQ-032 With macro UART_SEQ_WORD_COUNT_EN defined, word_count SHALL behave per REQ-028.
REQ-033 Without UART_SEQ_WORD_COUNT_EN, word_count SHALL be tied to 16'h0000 and its counter logic SHALL be absent; all other behaviour SHALL be unchanged.

Verification
REQ-034 Test: A,1,2,3,4 with word_ready=1 SHALL give word_out=16'h1234 and word_valid=1 one cycle after symbol 4; word_count=1.
REQ-035 Test: 5,A,1,2,3,4 from IDLE SHALL discard 5; A is sync; word_out SHALL be 16'h1234.
REQ-036 Test: sync followed by 8 data symbols with word_ready=0 SHALL give word 1 in word_out, then STALL with sym_ready=0; raising word_ready SHALL give word_out=word 2 the next cycle and return to COLLECT.
REQ-037 Test: sync,1,2 then 255 idle cycles SHALL set timeout_err=1 and frame_active=0; err_clear SHALL return timeout_err to 0.
REQ-038 Test: rst_n=0 asserted after sync,1,2,3 SHALL give word_valid=0 and word_count=0; sync,4,5,6,7 afterwards SHALL give 16'h4567.
REQ-039 Test: build without UART_SEQ_WORD_COUNT_EN and rerun REQ-034 -> word_count SHALL be 16'h0000 and word_out 16'h1234.
